// File: rtl/mod_pkg.sv
// -----------------------------------------------------------------------------
// mod_pkg
// Definitions shared by the modular-arithmetic blocks (mod_reduce_seq and its
// compare-and-subtract step).
//   state_e   : FSM encoding of the sequential reducer (IDLE=0, BUSY=1, DONE=2)
//   cnt_width : width of a counter that has to hold the value 2*bw
//   CNT_W     : that width at the default BITWIDTH of 32
// -----------------------------------------------------------------------------
package mod_pkg;

    localparam int BITWIDTH_DEF = 32;

    // Width of a counter that counts down from 2*bw to 0 inclusive.
    function automatic int cnt_width(input int bw);
        return $clog2(2 * bw + 1);
    endfunction

    localparam int CNT_W = cnt_width(BITWIDTH_DEF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mod_cond_sub.sv
// -----------------------------------------------------------------------------
// mod_cond_sub
// Combinational conditional subtract: r = (a >= q) ? a - q : a.
// The caller must guarantee a < 2*q, so that the result is always below q and
// fits in BITWIDTH bits.
// Ports:
//   a_i [BITWIDTH:0]   partial remainder (one bit wider than q)
//   q_i [BITWIDTH-1:0] modulus
//   r_o [BITWIDTH-1:0] reduced value, r_o < q_i
// -----------------------------------------------------------------------------
module mod_cond_sub #(
    parameter int BITWIDTH = 32
) (
    input  logic [BITWIDTH:0]   a_i,
    input  logic [BITWIDTH-1:0] q_i,
    output logic [BITWIDTH-1:0] r_o
);

    logic [BITWIDTH:0] q_ext;
    logic              ge;

    assign q_ext = {1'b0, q_i};
    assign ge    = (a_i >= q_ext);

    // The difference is below q whenever it is selected, so its top bit is
    // always zero and can be dropped.
    assign r_o = ge ? BITWIDTH'(a_i - q_ext) : a_i[BITWIDTH-1:0];

endmodule

// File: rtl/mod_reduce_seq.sv
// -----------------------------------------------------------------------------
// mod_reduce_seq
// Bit-serial restoring modular reducer. It computes X mod Q for a
// 2*BITWIDTH-bit operand X and a BITWIDTH-bit modulus Q, one operand bit per
// enabled cycle, with a valid/ready handshake on both sides.
// Ports:
//   iClk, iRstN   clock; asynchronous active-low reset
//   iClr          synchronous clear; aborts the operation and wins over everything
//   iEn           advance enable for BUSY (the handshakes are unaffected)
//   iValid/oReady operand handshake; oReady is high only in IDLE
//   iData, iQ     operand X and modulus Q, sampled on the accept edge only
//   oValid/iReady result handshake
//   oData         X mod Q
//   oErr          valid together with oValid; 1 means Q was zero
// Optional feature: define MOD_REDUCE_SEQ_EARLY_EXIT_EN to finish in one
// cycle when X < Q at accept. Results are the same either way.
// -----------------------------------------------------------------------------
module mod_reduce_seq
    import mod_pkg::*;
#(
    parameter int BITWIDTH = 32
) (
    input  logic                  iClk,
    input  logic                  iRstN,
    input  logic                  iClr,
    input  logic                  iEn,
    input  logic                  iValid,
    output logic                  oReady,
    input  logic [2*BITWIDTH-1:0] iData,
    input  logic [BITWIDTH-1:0]   iQ,
    output logic                  oValid,
    input  logic                  iReady,
    output logic [BITWIDTH-1:0]   oData,
    output logic                  oErr
);

    localparam int XW = 2 * BITWIDTH;
    localparam int CW = cnt_width(BITWIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(XW);

    state_e                state_q, state_d;
    logic [XW-1:0]         x_q, x_d;
    logic [BITWIDTH-1:0]   q_q, q_d;
    // rem is always below Q once stored, so BITWIDTH bits are enough; only the
    // shifted value fed to the subtract step needs the extra bit.
    logic [BITWIDTH-1:0]   rem_q, rem_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BITWIDTH-1:0]   data_q, data_d;
    logic                  err_q, err_d;

    logic [BITWIDTH:0]     rem_shift;
    logic [BITWIDTH-1:0]   rem_step;

    assign rem_shift = {rem_q, x_q[XW-1]};

    mod_cond_sub #(
        .BITWIDTH (BITWIDTH)
    ) u_cond_sub (
        .a_i (rem_shift),
        .q_i (q_q),
        .r_o (rem_step)
    );

    always_comb begin
        // NOTE: every variable gets a default before the case statement, so
        // no path can leave one unassigned and infer a latch.
        state_d = state_q;
        x_d     = x_q;
        q_d     = q_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;

        if (iClr) begin
            state_d = ST_IDLE;
            x_d     = '0;
            q_d     = '0;
            rem_d   = '0;
            cnt_d   = '0;
            data_d  = '0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (iValid) begin
                        x_d   = iData;
                        q_d   = iQ;
                        rem_d = '0;
                        cnt_d = CNT_INIT;
                        err_d = 1'b0;
                        if (iQ == '0) begin
                            state_d = ST_DONE;
                            data_d  = '0;
                            err_d   = 1'b1;
`ifdef MOD_REDUCE_SEQ_EARLY_EXIT_EN
                        end else if ((iData[XW-1:BITWIDTH] == '0) &&
                                     (iData[BITWIDTH-1:0] < iQ)) begin
                            state_d = ST_DONE;
                            data_d  = iData[BITWIDTH-1:0];
`endif
                        end else begin
                            state_d = ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (iEn) begin
                        rem_d = rem_step;
                        x_d   = x_q << 1;
                        cnt_d = cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            state_d = ST_DONE;
                            data_d  = rem_step;
                            err_d   = 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    if (iReady) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: the datapath registers are reset along with the FSM so that the
    // output data starts at zero; this costs nothing on these small registers.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            q_q     <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the
            // same pre-edge values regardless of statement order.
            state_q <= state_d;
            x_q     <= x_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign oReady = (state_q == ST_IDLE);
    assign oValid = (state_q == ST_DONE);
    assign oData  = data_q;
    assign oErr   = err_q;

endmodule

// File: doc/mod_reduce_seq.md
Name: mod_reduce_seq

Overview:
Bit-serial modular reducer: accepts a 2*BITWIDTH-bit operand X and modulus Q, returns X mod Q in [0, Q).
Sits directly upstream of the registered modular adder, which requires both operands already below Q. Typical source is a full-width product or an unreduced coefficient.
Restoring shift/compare/subtract, one operand bit per cycle. Valid/ready handshake on both sides.

Parameters:
BITWIDTH, 32, width of Q and of the result; the input operand is 2*BITWIDTH bits.

Ports:
iClk  input  1  clock; all state changes on the rising edge.
iRstN  input  1  asynchronous active-low reset.
iClr  input  1  synchronous clear; aborts any operation and returns to IDLE.
iEn  input  1  advance enable for BUSY; 0 freezes the reduction, handshakes unaffected.
iValid  input  1  upstream operand valid.
oReady  output  1  block can accept; high only in IDLE.
iData  input  2*BITWIDTH  operand X.
iQ  input  BITWIDTH  modulus; sampled on accept.
oValid  output  1  result valid.
iReady  input  1  downstream accepts the result.
oData  output  BITWIDTH  X mod Q.
oErr  output  1  qualified by oValid; 1 means Q was zero.

Behaviour:
- Reset (iRstN=0, async): state IDLE; oReady=1; oValid=0; oData=0; oErr=0; internal remainder, counter, operand and Q registers cleared.
- iClr=1 at an edge: same result as reset, applied synchronously. iClr has priority over every handshake and over iEn.
- FSM states: IDLE, BUSY, DONE.
- IDLE: oReady=1. On iValid&&oReady, latch X, latch Q, set rem=0, set cnt=2*BITWIDTH.
  - If Q==0: go to DONE with oData=0 and oErr=1.
  - Otherwise: go to BUSY.
- BUSY: oReady=0. Each edge with iEn=1:
  - rem' = {rem, X[msb]}, computed at BITWIDTH+1 bits.
  - If rem' >= Q, rem = rem' - Q; else rem = rem'.
  - X shifts left by 1; cnt decrements.
  - When cnt reaches 0 after this update, go to DONE and drive oData=rem[BITWIDTH-1:0] with oErr=0.
  - With iEn=0 all state holds.
- Remainder invariant: rem < Q after every step, so the top bit of rem is only transient.
- DONE: oValid=1. oData and oErr hold stable until oValid&&iReady, then go to IDLE with oValid=0.
- Latency: oValid rises exactly 2*BITWIDTH enabled cycles after the accept edge (64 at default). The Q==0 path takes 1 cycle.
- Throughput: no overlap between operations; at most one accept every 2*BITWIDTH+2 cycles.
- iData and iQ are ignored outside the accept edge.
- Boundaries:
  - Q=1 gives 0.
  - X=0 gives 0.
  - X<Q gives X, after full latency unless the optional feature below is enabled.
  - Q=2^BITWIDTH-1 must not overflow; this is why rem carries BITWIDTH+1 bits.

Optional Feature:
Macro MOD_REDUCE_SEQ_EARLY_EXIT_EN.
- Defined: at accept, if Q!=0 and X<Q (upper half zero and lower half < Q), go straight to DONE with oData=X[BITWIDTH-1:0]. Latency is 1 cycle.
- Undefined: every nonzero-Q operand takes the full 2*BITWIDTH cycles.
- Results are identical either way; only latency differs.

Decomposition:
- Shared package mod_pkg holds:
  - the FSM state encoding (IDLE=0, BUSY=1, DONE=2);
  - localparam CNT_W=$clog2(2*BITWIDTH+1).
- One sub-module, mod_cond_sub: combinational BITWIDTH+1-bit compare-and-subtract step (rem', Q -> rem).
  - Reusable by the modular adder family.
  - Unit-tested separately.

Test Plan:
1. Reset, then X=100, Q=17, iReady=1: oValid at cycle 64 after accept, oData=15, oErr=0; oReady low from accept until IDLE.
2. X=2^64-1, Q=0xFFFFFFFB: oData=24. Then X=0, Q=0xFFFFFFFF: oData=0. Then X=0xFFFFFFFE, Q=0xFFFFFFFF: oData=0xFFFFFFFE.
3. Q=0, X=5: oValid next cycle, oErr=1, oData=0. Then Q=1, X=12345: oData=0, oErr=0.
4. X=100, Q=17, hold iReady=0 for 5 cycles in DONE: oValid, oData=15 and oErr stable throughout; completes on iReady=1; next accept accepted the following cycle.
5. Mid-BUSY abort:
   - Deassert iRstN at cycle 20: outputs zero immediately.
   - Repeat with iClr at cycle 20: zero at the next edge.
   - In both cases a new X=50, Q=7 then returns 1.
   - iEn low 10 cycles during BUSY: latency is 74, result unchanged.
6. With MOD_REDUCE_SEQ_EARLY_EXIT_EN defined, X=16, Q=17: oData=16 after 1 cycle; X=17, Q=17: full latency, oData=0.
